// File: rtl/snax_spm_port_arbiter.sv
// snax_spm_port_arbiter
//   Shares one single-port scratchpad between NumPorts mem-style requesters.
//   A round-robin arbiter picks one request per cycle. The index of every accepted
//   request goes into an in-order FIFO, so each memory response is returned to the
//   port that issued it. A flush handshake stops new grants and waits for all
//   in-flight requests to return, so the memory can be reconfigured or reloaded.
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/gnt_o           per-port request valid / grant (one-hot or zero)
//   addr_i, we_i,
//   wdata_i, strb_i       per-port request payload (byte address)
//   rvalid_o, rdata_o     per-port response valid, shared response data
//   mem_*                 scratchpad request/response channel (word address)
//   flush_i/flush_done_o  level drain request / drained-and-held indication
//   err_o                 sticky: response arrived with nothing in flight
module snax_spm_port_arbiter #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MemAddrWidth   = 16,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth     = DataWidth / 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumPorts-1:0]                req_i,
  output logic [NumPorts-1:0]                gnt_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
  input  logic [NumPorts-1:0]                we_i,
  input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumPorts-1:0][StrbWidth-1:0] strb_i,
  output logic [NumPorts-1:0]                rvalid_o,
  output logic [DataWidth-1:0]               rdata_o,
  output logic                               mem_valid_o,
  input  logic                               mem_ready_i,
  output logic                               mem_we_o,
  output logic [MemAddrWidth-1:0]            mem_addr_o,
  output logic [DataWidth-1:0]               mem_wdata_o,
  output logic [StrbWidth-1:0]               mem_be_o,
  input  logic                               mem_rvalid_i,
  input  logic [DataWidth-1:0]               mem_rdata_i,
  input  logic                               flush_i,
  output logic                               flush_done_o,
  output logic                               err_o
);

  localparam int unsigned OffW = $clog2(StrbWidth);
  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  // MaxOutstanding is a power of two, so the FIFO pointers wrap naturally.
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_e;

  state_e          state;
  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] win;
  logic [IdxW-1:0] cand;
  logic            win_vld;
  logic [IdxW-1:0] idx_fifo [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] count_nxt;
  logic            full;
  logic            empty;
  logic            can_grant;
  logic            push;
  logic            pop;

  // Byte offset and the address bits above the scratchpad size are dropped on
  // purpose: larger addresses alias onto the memory.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  assign full  = (count == CntW'(MaxOutstanding));
  assign empty = (count == '0);
  // Full is judged on the registered count, so a pop in the same cycle does not
  // open a slot until the next cycle. A rising flush_i blocks grants at once.
  assign can_grant = !rst_i && (state == RUN) && !flush_i && !full;

  // Round-robin search: walk offsets from the highest down so the last hit,
  // which wins, is the first requester at/after the pointer.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      cand = IdxW'((32'(rr_ptr) + 32'(i)) % NumPorts);
      if (req_i[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign mem_valid_o = can_grant && win_vld;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    gnt_o       = '0;
    if (mem_valid_o) begin
      mem_we_o    = we_i[win];
      mem_addr_o  = addr_i[win][MemAddrWidth+OffW-1:OffW];
      mem_wdata_o = wdata_i[win];
      mem_be_o    = strb_i[win];
      gnt_o[win]  = mem_ready_i;
    end
  end

  assign push = mem_valid_o && mem_ready_i;
  // A response with nothing in flight is not forwarded; it only raises err_o.
  assign pop  = mem_rvalid_i && !empty;

  assign count_nxt = count + CntW'(push) - CntW'(pop);

  // Responses pass straight through to the port at the FIFO head.
  always_comb begin
    rvalid_o = '0;
    if (pop) rvalid_o[idx_fifo[rd_ptr]] = 1'b1;
  end

  assign rdata_o = pop ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_o        <= 1'b0;
      state        <= RUN;
      flush_done_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
        rr_ptr <= (win == IdxW'(NumPorts - 1)) ? '0 : win + IdxW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PtrW'(1);
      count <= count_nxt;
      if (mem_rvalid_i && empty) err_o <= 1'b1;

      case (state)
        RUN: begin
          if (flush_i) state <= DRAIN;
        end
        DRAIN: begin
          if (!flush_i) begin
            state <= RUN;
          end else if (count_nxt == '0) begin
            // Look at the next count so done rises right after the last response.
            state        <= HOLD;
            flush_done_o <= 1'b1;
          end
        end
        HOLD: begin
          if (!flush_i) begin
            state        <= RUN;
            flush_done_o <= 1'b0;
          end
        end
        default: begin
          state        <= RUN;
          flush_done_o <= 1'b0;
        end
      endcase
    end
  end

  // Index storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push) idx_fifo[wr_ptr] <= win;
  end

endmodule
